gshare_predictor: RTL and testbench
===================================

# gshare_predictor

Parametrised two-level dynamic branch predictor. It is the successor to the fixed 5-bit `level_2_predictor`. It adds the following:
- configurable PC width, history length, table depth and counter width;
- selectable gshare or gselect indexing;
- separate predict and resolve ports;
- asynchronous reset.

It sits beside the fetch stage: fetch issues a lookup per branch PC, and the execute stage returns the resolved direction to train the table.

## Interface
- `PC_W`, 5, branch PC width
- `HIST_W`, 4, global history register (GHR) length; legal range 1..`IDX_W`
- `IDX_W`, 4, pattern-table index width; depth = 2^`IDX_W` entries
- `CNT_W`, 2, saturating counter width (≥2)
- `GSHARE`, 1, 1 = XOR indexing, 0 = concatenated (gselect) indexing
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pred_valid`  in  1  lookup request this cycle
- `pred_pc`  in  `PC_W`  PC of branch to predict
- `pred_out_valid`  out  1  one-cycle pulse, prediction available
- `pred_taken`  out  1  predicted direction (1 = taken)
- `pred_idx`  out  `IDX_W`  table index used for the prediction
- `upd_valid`  in  1  resolved branch this cycle
- `upd_pc`  in  `PC_W`  PC of resolved branch
- `upd_taken`  in  1  actual direction

## Operation
- **Index function:** uses `pc[IDX_W-1:0]` and the GHR. `PC_W` < `IDX_W` is illegal.
  - `GSHARE`=1: index = `pc[IDX_W-1:0]` XOR the GHR zero-extended at the MSB.
  - `GSHARE`=0: index = {`pc[IDX_W-HIST_W-1:0]`, GHR}. When `HIST_W`==`IDX_W`, the PC is unused.
- **Table:** 2^`IDX_W` counters of `CNT_W` bits. Predict taken iff the counter MSB = 1.
- **Lookup:** on `pred_valid`, the index is computed from `pred_pc` and the current GHR. The counter MSB is registered into `pred_taken`, and the index into `pred_idx`.
- **Update:** on `upd_valid`, the index is computed from `upd_pc` and the current GHR.
  - Counter: +1 if `upd_taken`, −1 otherwise. It saturates at 2^`CNT_W`−1 and at 0; there is no wrap.
  - GHR shifts left with `upd_taken` entering at the LSB; the oldest bit is discarded.
- **GHR policy:** the GHR is non-speculative. Only `upd_valid` changes it; lookups never do.
- **Same-cycle lookup and update, any indices:** the lookup uses the pre-edge counter and pre-edge GHR. The update commits at the same edge.
- **Back-to-back updates to the same index:** each update sees the previous cycle's committed value. No update is lost.
- **Reset** (asserted asynchronously, regardless of the clock):
  - every counter = 2^(`CNT_W`−1)−1 (weakly not-taken; 2'b01 for `CNT_W`=2);
  - GHR = 0;
  - `pred_out_valid`, `pred_taken`, `pred_idx` = 0.
  - An in-flight lookup or update at reset is dropped.
  - Release is synchronous to the next rising edge.

## Timing
- **Lookup latency:** 1 cycle. `pred_valid` sampled at edge N gives `pred_out_valid`=1 during cycle N+1 only.
- **Output hold:** `pred_taken` and `pred_idx` hold until the next accepted lookup.
- **Throughput:** one lookup and one update per cycle, with no stalls and no backpressure.
- **Update visibility:** an update at edge N is visible to a lookup sampled at edge N+1.

## Configuration
- **`PRED_STATS_EN` defined:** adds the outputs `stat_upd` [15:0] and `stat_miss` [15:0].
  - Both reset to 0.
  - `stat_upd` increments on each `upd_valid`.
  - `stat_miss` increments when the pre-update counter MSB ≠ `upd_taken`.
  - Both saturate at 16'hFFFF.
- **`PRED_STATS_EN` undefined:** the ports and logic are absent, and predictor behaviour is identical.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-cycle, then look up PC=5'b01100.
  - Outputs go to 0 immediately (asynchronously).
  - After release, the lookup gives `pred_taken`=0 with `pred_idx`=4'b1100.
- **Saturation:** six taken updates on PC=5'b00011 with GHR forced constant (history is all-taken after 4 updates, so use `HIST_W`=1 with prior taken history).
  - Counter reaches 2'b11 and stays there.
  - Next lookup gives taken.
  - One not-taken update leaves the prediction still taken.
- **Pattern learning:** repeat T NT T T NT on PC=5'b01100 for 20 updates, with a lookup issued the cycle before each update.
  - Predictions for updates 11–20 are all correct.
  - With `PRED_STATS_EN` defined, `stat_miss` is unchanged after update 10 and `stat_upd`=20.
- **Same-cycle hazard:** lookup and update hit the same index in one cycle, with counter=2'b01 and `upd_taken`=1.
  - `pred_taken`=0 (old value).
  - A lookup on the following cycle gives 1.
- **gselect mode:** `GSHARE`=0, `HIST_W`=2, `IDX_W`=4, GHR=2'b10, `pred_pc`=5'b00111 → `pred_idx`=4'b1110.
- **Reset mid-training:** after the pattern-learning scenario, pulse `rst_n` low.
  - All counters return to weakly not-taken, GHR = 0 and the stats counters = 0.
  - The first lookup predicts not-taken.

Source files
------------

// File: rtl/gshare_predictor.sv
// ---------------------------------------------------------------------------
// gshare_predictor
//
// Two-level dynamic branch predictor with a global history register (GHR)
// and a table of saturating counters. The fetch stage issues a lookup on
// the predict port. The execute stage returns resolved directions on the
// update port, and these train the table and shift the GHR.
//
// Parameters:
//   PC_W   - branch PC width (must be >= IDX_W)
//   HIST_W - GHR length, 1..IDX_W
//   IDX_W  - table index width, depth = 2**IDX_W
//   CNT_W  - saturating counter width (>= 2)
//   GSHARE - 1: index = pc XOR history, 0: index = {pc, history} (gselect)
//
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   pred_valid      - lookup request
//   pred_pc         - PC to predict
//   pred_out_valid  - one-cycle pulse, prediction registered
//   pred_taken      - predicted direction, held until next lookup
//   pred_idx        - table index used, held until next lookup
//   upd_valid       - resolved branch
//   upd_pc          - PC of resolved branch
//   upd_taken       - actual direction
//
// Optional build macro PRED_STATS_EN adds:
//   stat_upd        - saturating count of updates
//   stat_miss       - saturating count of updates whose pre-update
//                     prediction disagreed with the outcome
// ---------------------------------------------------------------------------
module gshare_predictor #(
  parameter int unsigned PC_W   = 5,
  parameter int unsigned HIST_W = 4,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned GSHARE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_valid,
  input  logic [PC_W-1:0]   pred_pc,
  output logic              pred_out_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken
`ifdef PRED_STATS_EN
  ,
  output logic [15:0]       stat_upd,
  output logic [15:0]       stat_miss
`endif
);

  localparam int unsigned      DEPTH    = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MIN  = '0;

  logic [CNT_W-1:0]  pht [DEPTH];
  logic [HIST_W-1:0] ghr;

  logic [IDX_W-1:0]  lkp_idx;
  logic [IDX_W-1:0]  upd_idx;
  logic [CNT_W-1:0]  upd_cnt;
  logic [CNT_W-1:0]  upd_cnt_next;
  logic [HIST_W:0]   ghr_shift;
  logic [HIST_W-1:0] ghr_next;

  // Only the low IDX_W PC bits take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc, upd_pc};

  // Index function. Bit-wise loops keep both modes legal for every
  // HIST_W/IDX_W combination, including HIST_W == IDX_W where gselect
  // uses no PC bits at all.
  function automatic logic [IDX_W-1:0] calc_idx(input logic [PC_W-1:0]   pc,
                                                input logic [HIST_W-1:0] hist);
    logic [IDX_W-1:0] hist_ext;
    logic [IDX_W-1:0] idx;
    hist_ext = '0;
    hist_ext[HIST_W-1:0] = hist;
    if (GSHARE != 0) begin
      idx = pc[IDX_W-1:0] ^ hist_ext;
    end else begin
      idx = hist_ext;
      for (int unsigned i = HIST_W; i < IDX_W; i++) begin
        idx[i] = pc[i-HIST_W];
      end
    end
    return idx;
  endfunction

  always_comb begin
    lkp_idx = calc_idx(pred_pc, ghr);
    upd_idx = calc_idx(upd_pc, ghr);
  end

  // Saturating counter step for the entry being trained.
  always_comb begin
    upd_cnt      = pht[upd_idx];
    upd_cnt_next = upd_cnt;
    if (upd_taken) begin
      if (upd_cnt != CNT_MAX) upd_cnt_next = upd_cnt + 1'b1;
    end else begin
      if (upd_cnt != CNT_MIN) upd_cnt_next = upd_cnt - 1'b1;
    end
  end

  // The newest outcome enters at the LSB and the oldest bit falls off.
  always_comb begin
    ghr_shift = {ghr, upd_taken};
    ghr_next  = ghr_shift[HIST_W-1:0];
  end

  // Pattern table. A lookup in the same cycle as an update reads the
  // pre-edge value because the write lands at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pht[i] <= CNT_INIT;
      end
    end else if (upd_valid) begin
      pht[upd_idx] <= upd_cnt_next;
    end
  end

  // The history is non-speculative, so only resolved branches move it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (upd_valid) begin
      ghr <= ghr_next;
    end
  end

  // Registered prediction outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
      pred_idx       <= '0;
    end else begin
      pred_out_valid <= pred_valid;
      if (pred_valid) begin
        pred_taken <= pht[lkp_idx][CNT_W-1];
        pred_idx   <= lkp_idx;
      end
    end
  end

`ifdef PRED_STATS_EN
  logic upd_miss;
  assign upd_miss = upd_cnt[CNT_W-1] != upd_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_upd  <= '0;
      stat_miss <= '0;
    end else if (upd_valid) begin
      if (stat_upd != '1) stat_upd <= stat_upd + 16'd1;
      if (upd_miss && (stat_miss != '1)) stat_miss <= stat_miss + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pred_valid = 1'b0;
  logic [4:0] pred_pc = '0;
  logic       pred_out_valid;
  logic       pred_taken;
  logic [3:0] pred_idx;
  logic       upd_valid = 1'b0;
  logic [4:0] upd_pc = '0;
  logic       upd_taken = 1'b0;

  logic       g_pred_valid = 1'b0;
  logic [4:0] g_pred_pc = '0;
  logic       g_pred_out_valid;
  logic       g_pred_taken;
  logic [3:0] g_pred_idx;
  logic       g_upd_valid = 1'b0;
  logic [4:0] g_upd_pc = '0;
  logic       g_upd_taken = 1'b0;

`ifdef PRED_STATS_EN
  logic [15:0] stat_upd, stat_miss, g_stat_upd, g_stat_miss;
`endif

  always #5 clk = ~clk;

  gshare_predictor #(
    .PC_W(5), .HIST_W(4), .IDX_W(4), .CNT_W(2), .GSHARE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_out_valid(pred_out_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken)
`ifdef PRED_STATS_EN
    , .stat_upd(stat_upd), .stat_miss(stat_miss)
`endif
  );

  gshare_predictor #(
    .PC_W(5), .HIST_W(2), .IDX_W(4), .CNT_W(2), .GSHARE(0)
  ) dut_gsel (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(g_pred_valid), .pred_pc(g_pred_pc),
    .pred_out_valid(g_pred_out_valid), .pred_taken(g_pred_taken), .pred_idx(g_pred_idx),
    .upd_valid(g_upd_valid), .upd_pc(g_upd_pc), .upd_taken(g_upd_taken)
`ifdef PRED_STATS_EN
    , .stat_upd(g_stat_upd), .stat_miss(g_stat_miss)
`endif
  );

  typedef struct {
    logic       taken;
    logic [3:0] idx;
  } exp_t;

  typedef struct {
    logic [4:0] pc;
    logic       exp_taken;
    logic [3:0] exp_idx;
  } vec_t;

  // Reference model of the default-configuration predictor.
  logic [1:0]  m_pht [16];
  logic [3:0]  m_ghr;
  int unsigned m_upd, m_miss;
  exp_t        sb[$];
  exp_t        last_exp;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pht[i] = 2'b01;
    m_ghr = '0;
    m_upd = 0;
    m_miss = 0;
    sb.delete();
    last_exp.taken = 1'b0;
    last_exp.idx = '0;
  endtask

  // One clock of stimulus on the main DUT. The expected lookup result is
  // queued when driven (from the model, or from a hand value when ovr=1)
  // and compared once the registered output appears.
  task automatic drive(input logic pv, input logic [4:0] ppc,
                       input logic uv, input logic [4:0] upc, input logic ut,
                       input logic ovr, input logic ot, input logic [3:0] oi);
    exp_t e;
    logic [3:0] ui;
    pred_valid = pv; pred_pc = ppc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut;
    if (pv) begin
      e.idx = ppc[3:0] ^ m_ghr;
      e.taken = m_pht[e.idx][1];
      if (ovr) begin
        e.taken = ot;
        e.idx = oi;
      end
      sb.push_back(e);
    end
    @(posedge clk);
    if (uv) begin
      ui = upc[3:0] ^ m_ghr;
      if (m_upd < 32'hFFFF) m_upd++;
      if ((m_pht[ui][1] != ut) && (m_miss < 32'hFFFF)) m_miss++;
      if (ut && (m_pht[ui] != 2'b11)) m_pht[ui] = m_pht[ui] + 2'd1;
      else if (!ut && (m_pht[ui] != 2'b00)) m_pht[ui] = m_pht[ui] - 2'd1;
      m_ghr = {m_ghr[2:0], ut};
    end
    #1;
    check("pred_out_valid", 32'(pred_out_valid), 32'(pv));
    if (pv) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'(1), 32'(0));
      end else begin
        last_exp = sb.pop_front();
      end
    end
    check("pred_taken", 32'(pred_taken), 32'(last_exp.taken));
    check("pred_idx", 32'(pred_idx), 32'(last_exp.idx));
`ifdef PRED_STATS_EN
    check("stat_upd", 32'(stat_upd), m_upd);
    check("stat_miss", 32'(stat_miss), m_miss);
`endif
    pred_valid = 1'b0;
    upd_valid = 1'b0;
  endtask

  task automatic g_step(input logic pv, input logic [4:0] ppc,
                        input logic uv, input logic [4:0] upc, input logic ut);
    g_pred_valid = pv; g_pred_pc = ppc;
    g_upd_valid = uv; g_upd_pc = upc; g_upd_taken = ut;
    @(posedge clk);
    #1;
    g_pred_valid = 1'b0;
    g_upd_valid = 1'b0;
  endtask

  // Asynchronous assertion between edges, release away from the edge.
  task automatic reset_pulse(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check({tag, "_async_valid"}, 32'(pred_out_valid), 32'(0));
    check({tag, "_async_taken"}, 32'(pred_taken), 32'(0));
    check({tag, "_async_idx"}, 32'(pred_idx), 32'(0));
`ifdef PRED_STATS_EN
    check({tag, "_async_stat_upd"}, 32'(stat_upd), 32'(0));
    check({tag, "_async_stat_miss"}, 32'(stat_miss), 32'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  bit   pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  vec_t vecs [17];

  initial begin
    logic pred_before;
    logic [15:0] miss_at_10;
    miss_at_10 = '0;

    // Every entry weakly not-taken after reset; with GHR = 0 the gshare
    // index is just the low PC bits.
    for (int i = 0; i < 16; i++) begin
      vecs[i].pc = 5'(i) | ((i % 2 == 1) ? 5'h10 : 5'h00);
      vecs[i].exp_taken = 1'b0;
      vecs[i].exp_idx = 4'(i);
    end
    vecs[16].pc = 5'b01100;
    vecs[16].exp_taken = 1'b0;
    vecs[16].exp_idx = 4'b1100;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(pred_out_valid), 32'(0));
    check("reset_taken", 32'(pred_taken), 32'(0));
    check("reset_idx", 32'(pred_idx), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // gselect: two updates set GHR = 2'b10, then pc 00111 -> {11,10}.
    g_step(1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
    g_step(1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
    g_step(1'b1, 5'b00111, 1'b0, 5'd0, 1'b0);
    check("gsel_valid", 32'(g_pred_out_valid), 32'(1));
    check("gsel_idx", 32'(g_pred_idx), 32'(4'b1110));
    check("gsel_taken", 32'(g_pred_taken), 32'(0));
    // Same-cycle lookup/update at 1110: lookup sees old counter 01.
    g_step(1'b1, 5'b00111, 1'b1, 5'b00111, 1'b1);
    check("gsel_hazard_taken", 32'(g_pred_taken), 32'(0));
    check("gsel_hazard_idx", 32'(g_pred_idx), 32'(4'b1110));
    // GHR now 01; a not-taken update brings it back to 10.
    g_step(1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
    g_step(1'b1, 5'b00111, 1'b0, 5'd0, 1'b0);
    check("gsel_trained_taken", 32'(g_pred_taken), 32'(1));
    check("gsel_trained_idx", 32'(g_pred_idx), 32'(4'b1110));
    g_step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    check("gsel_pulse", 32'(g_pred_out_valid), 32'(0));
    check("gsel_hold_idx", 32'(g_pred_idx), 32'(4'b1110));

    // Reset values then asynchronous reset of non-zero outputs.
    drive(1'b1, 5'b01100, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b1100);
    drive(1'b1, 5'b01111, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b1111);
    reset_pulse("rst1");
    drive(1'b1, 5'b01100, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b1100);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Pattern learning: lookup, then the update on the next cycle.
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 5'b01100, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      pred_before = pred_taken;
      drive(1'b0, 5'd0, 1'b1, 5'b01100, pat[k % 5], 1'b0, 1'b0, 4'd0);
      if (k >= 10) check("pattern_correct", 32'(pred_before), 32'(pat[k % 5]));
`ifdef PRED_STATS_EN
      if (k == 9) miss_at_10 = stat_miss;
`endif
    end
`ifdef PRED_STATS_EN
    check("pattern_stat_upd", 32'(stat_upd), 32'(20));
    check("pattern_stat_miss_flat", 32'(stat_miss), 32'(miss_at_10));
`endif

    // Reset mid-training: the table-driven sweep sees every entry reset.
    reset_pulse("rst2");
    for (int v = 0; v < 17; v++) begin
      drive(1'b1, vecs[v].pc, 1'b0, 5'd0, 1'b0, 1'b1, vecs[v].exp_taken, vecs[v].exp_idx);
    end

    // Same-cycle hazard at index 0101, then next-cycle visibility
    // (GHR is now 0001, so pc 00100 maps to 0101 again).
    drive(1'b1, 5'b00101, 1'b1, 5'b00101, 1'b1, 1'b1, 1'b0, 4'b0101);
    drive(1'b1, 5'b00100, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 4'b0101);

    // Saturation: after four taken updates GHR = 1111 and pc 00011 keeps
    // hitting entry 1100, which saturates at 11.
    reset_pulse("rst3");
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 5'd0, 1'b1, 5'b00011, 1'b1, 1'b0, 1'b0, 4'd0);
    end
    drive(1'b1, 5'b00011, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 4'b1100);
    drive(1'b0, 5'd0, 1'b1, 5'b00011, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 5'b00010, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 4'b1100);
    drive(1'b0, 5'd0, 1'b1, 5'b00010, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 5'b00000, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b1100);

    // Random traffic against the model, including back-to-back updates
    // and same-cycle collisions.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'b0, 1'b0, 4'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
